// File: rtl/bt656_pkg.sv
// bt656_pkg
//   Shared BT.656 definitions for the timing decoder and its downstream
//   consumers (scrambler/descrambler regenerator).
//   - TRS preamble words (3FF, 000)
//   - XY flag bit positions (F=8, V=7, H=6), parity occupies [5:2]
//   - Lock FSM state encoding
//   - NTSC line/frame defaults
//   - word_match(): preamble compare, optionally ignoring the two LSBs
package bt656_pkg;

  localparam logic [9:0] TRS_PRE_1 = 10'h3FF;
  localparam logic [9:0] TRS_PRE_0 = 10'h000;

  localparam int unsigned XY_F_BIT = 8;
  localparam int unsigned XY_V_BIT = 7;
  localparam int unsigned XY_H_BIT = 6;

  localparam int unsigned NTSC_LINE_WORDS = 1716;
  localparam int unsigned NTSC_LINE_COUNT = 525;

  typedef enum logic [1:0] {
    LOCK_UNLOCKED = 2'd0,
    LOCK_ACQUIRE  = 2'd1,
    LOCK_LOCKED   = 2'd2
  } lock_state_t;

  typedef struct packed {
    logic f;
    logic v;
    logic h;
    logic ok;
  } xy_flags_t;

  // An 8-bit source pads the two LSBs; their content is then meaningless.
  function automatic logic word_match(input logic [9:0] a,
                                      input logic [9:0] b,
                                      input logic       cmp8);
    if (cmp8) return a[9:2] == b[9:2];
    return a == b;
  endfunction

endpackage

// File: rtl/bt656_timing_decoder_if.sv
// bt656_timing_decoder_if
//   Stream and timing bundle of the BT.656 timing decoder.
//   bt656_stream_in  : raw 10-bit BT.656 word
//   bt656_stream_out : input delayed one cycle
//   trs_valid        : pulse, valid XY word on bt656_stream_out
//   H, V, F          : last valid XY flags
//   xy_error         : pulse, XY protection/format failure
//   sample_count     : word index within the line (EAV 3FF = 0)
//   line_count       : line index within the frame
//   frame_start      : pulse, line_count cleared by an F falling edge
//   locked           : timing lock status
//   slave  : the decoder side; master : the stream source / consumer side.
interface bt656_timing_decoder_if;

  logic [9:0]  bt656_stream_in;
  logic [9:0]  bt656_stream_out;
  logic        trs_valid;
  logic        H;
  logic        V;
  logic        F;
  logic        xy_error;
  logic [10:0] sample_count;
  logic [9:0]  line_count;
  logic        frame_start;
  logic        locked;

  modport master (
    output bt656_stream_in,
    input  bt656_stream_out, trs_valid, H, V, F, xy_error,
    input  sample_count, line_count, frame_start, locked
  );

  modport slave (
    input  bt656_stream_in,
    output bt656_stream_out, trs_valid, H, V, F, xy_error,
    output sample_count, line_count, frame_start, locked
  );

endinterface

// File: rtl/bt656_xy_check.sv
// bt656_xy_check
//   Combinational decode and protection check of a BT.656 XY word.
//   xy_word : bits [9:2] of the XY word = {1, F, V, H, P3, P2, P1, P0}
//   flags   : {f, v, h, ok}; ok = bit 9 set and all four parity bits correct
module bt656_xy_check
  import bt656_pkg::*;
(
  input  logic [9:2] xy_word,
  output xy_flags_t  flags
);

  logic       f;
  logic       v;
  logic       h;
  logic [3:0] p_exp;

  always_comb begin
    f     = xy_word[XY_F_BIT];
    v     = xy_word[XY_V_BIT];
    h     = xy_word[XY_H_BIT];
    p_exp = {v ^ h, f ^ h, f ^ v, f ^ v ^ h};

    flags.f  = f;
    flags.v  = v;
    flags.h  = h;
    flags.ok = xy_word[9] && (xy_word[5:2] == p_exp);
  end

endmodule

// File: rtl/bt656_timing_decoder.sv
// bt656_timing_decoder
//   Parses a raw BT.656 stream, detects and checks every TRS, and publishes
//   registered H/V/F, sample/line position and lock status, cycle-aligned
//   with the stream delayed by one cycle.
//   Parameters:
//     LINE_WORDS   : words per line (sample_count wrap)
//     LINE_COUNT   : lines per frame (line_count wrap)
//     LOCK_LINES   : consecutive on-time EAVs needed for lock
//     COMPARE_8BIT : 1 = preamble compare on bits [9:2] only
//   Ports:
//     clk     : pixel clock
//     reset_n : asynchronous active-low reset
//     bus     : stream/timing bundle (slave side)
module bt656_timing_decoder
  import bt656_pkg::*;
#(
  parameter int unsigned LINE_WORDS   = NTSC_LINE_WORDS,
  parameter int unsigned LINE_COUNT   = NTSC_LINE_COUNT,
  parameter int unsigned LOCK_LINES   = 4,
  parameter bit          COMPARE_8BIT = 1'b1
) (
  input logic                   clk,
  input logic                   reset_n,
  bt656_timing_decoder_if.slave bus
);

  localparam int unsigned      GW        = $clog2(LOCK_LINES + 1);
  localparam logic [10:0]      SC_LAST   = 11'(LINE_WORDS - 1);
  localparam logic [10:0]      SC_XY     = 11'd3;
  localparam logic [9:0]       LC_LAST   = 10'(LINE_COUNT - 1);
  localparam logic [GW-1:0]    GOOD_LOCK = GW'(LOCK_LINES);

  // History, oldest in hist2_q.
  logic [9:0]  hist0_q;
  logic [9:0]  hist1_q;
  logic [9:0]  hist2_q;

  logic [9:0]  stream_q;
  logic        trs_valid_q;
  logic        xy_error_q;
  logic        h_q;
  logic        v_q;
  logic        f_q;
  logic [10:0] sc_q;
  logic [9:0]  lc_q;
  logic        frame_start_q;
  logic        locked_q;

  lock_state_t   state_q;
  lock_state_t   state_d;
  logic [GW-1:0] good_q;
  logic [GW-1:0] good_d;

  xy_flags_t   xy;
  logic        preamble_hit;
  logic        trs_good;
  logic        trs_bad;
  logic        eav_good;
  logic        on_time;
  logic        frame_edge;
  logic [10:0] sc_free;
  logic [10:0] sc_d;
  logic [9:0]  lc_d;

  bt656_xy_check u_xy_check (
    .xy_word (bus.bt656_stream_in[9:2]),
    .flags   (xy)
  );

  // Event decode for the word currently on the input.
  always_comb begin
    preamble_hit = word_match(hist2_q, TRS_PRE_1, COMPARE_8BIT) &&
                   word_match(hist1_q, TRS_PRE_0, COMPARE_8BIT) &&
                   word_match(hist0_q, TRS_PRE_0, COMPARE_8BIT);
    trs_good     = preamble_hit && xy.ok;
    trs_bad      = preamble_hit && !xy.ok;
    eav_good     = trs_good && xy.h;

    sc_free      = (sc_q == SC_LAST) ? '0 : sc_q + 11'd1;
    // On-time is judged against the free-running count, before any resync.
    on_time      = (sc_free == SC_XY);
    sc_d         = eav_good ? SC_XY : sc_free;

    frame_edge   = eav_good && !xy.f && f_q;
    lc_d         = lc_q;
    if (frame_edge) begin
      lc_d = '0;
    end else if (eav_good) begin
      lc_d = (lc_q == LC_LAST) ? '0 : lc_q + 10'd1;
    end
  end

  // Lock FSM, next state.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      LOCK_UNLOCKED: begin
        if (eav_good) begin
          state_d = LOCK_ACQUIRE;
          good_d  = GW'(1);
        end
      end
      LOCK_ACQUIRE: begin
        if (trs_bad) begin
          state_d = LOCK_UNLOCKED;
        end else if (eav_good) begin
          if (on_time) begin
            good_d = good_q + GW'(1);
            if (good_d == GOOD_LOCK) state_d = LOCK_LOCKED;
          end else begin
            good_d = GW'(1);
          end
        end
      end
      LOCK_LOCKED: begin
        // A bad XY in the EAV slot is both an error and a missed EAV;
        // either term alone already yields the single drop to UNLOCKED.
        if (trs_bad || (eav_good && !on_time) || (on_time && !eav_good)) begin
          state_d = LOCK_UNLOCKED;
        end
      end
      default: begin
        state_d = LOCK_UNLOCKED;
        good_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOCK_UNLOCKED;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist0_q       <= '0;
      hist1_q       <= '0;
      hist2_q       <= '0;
      stream_q      <= '0;
      trs_valid_q   <= 1'b0;
      xy_error_q    <= 1'b0;
      h_q           <= 1'b0;
      v_q           <= 1'b0;
      f_q           <= 1'b0;
      sc_q          <= '0;
      lc_q          <= '0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      hist0_q       <= bus.bt656_stream_in;
      hist1_q       <= hist0_q;
      hist2_q       <= hist1_q;
      stream_q      <= bus.bt656_stream_in;
      trs_valid_q   <= trs_good;
      xy_error_q    <= trs_bad;
      if (trs_good) begin
        h_q <= xy.h;
        v_q <= xy.v;
        f_q <= xy.f;
      end
      sc_q          <= sc_d;
      lc_q          <= lc_d;
      frame_start_q <= frame_edge;
      locked_q      <= (state_d == LOCK_LOCKED);
    end
  end

  assign bus.bt656_stream_out = stream_q;
  assign bus.trs_valid        = trs_valid_q;
  assign bus.xy_error         = xy_error_q;
  assign bus.H                = h_q;
  assign bus.V                = v_q;
  assign bus.F                = f_q;
  assign bus.sample_count     = sc_q;
  assign bus.line_count       = lc_q;
  assign bus.frame_start      = frame_start_q;
  assign bus.locked           = locked_q;

endmodule

// File: doc/bt656_timing_decoder.md
# bt656_timing_decoder

Front-end timing stage directly upstream of `scrambler`. It parses the raw 10-bit BT.656 stream, detects and protection-checks every timing reference sequence (TRS), and publishes registered H/V/F flags, sample and line position, and a lock status. It forwards the video words with fixed latency, so the downstream scrambler/descrambler gets data and timing that are cycle-aligned.

## Interface
- `LINE_WORDS`, 1716: words per line (2 × 858, NTSC).
- `LINE_COUNT`, 525: lines per frame; line-counter wrap bound.
- `LOCK_LINES`, 4: consecutive on-time EAVs required to declare lock.
- `COMPARE_8BIT`, 1: 1 = compare only bits [9:2] (8-bit source, LSBs zero-padded); 0 = compare all 10 bits.
- `clk` in 1: pixel clock, single clock domain.
- `reset_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `bt656_stream_in` in 10: raw BT.656 word.
- `bt656_stream_out` out 10: `bt656_stream_in` delayed exactly 1 cycle, unmodified.
- `trs_valid` out 1: one-cycle pulse while `bt656_stream_out` carries a valid XY word.
- `H`, `V`, `F` out 1 each: last valid XY flags.
- `xy_error` out 1: one-cycle pulse, XY protection/format failure.
- `sample_count` out 11: word index within line of `bt656_stream_out`; EAV 3FF word = 0.
- `line_count` out 10: line index within frame.
- `frame_start` out 1: one-cycle pulse when `line_count` is cleared by an F edge.
- `locked` out 1: timing lock status.

## Operation
- History: 3 registered previous input words. A TRS is detected when history = 3FF, 000, 000 (oldest first) and the current input word is XY. Compare width follows `COMPARE_8BIT`.
- XY check on bits [9:2] = {1, F, V, H, P3, P2, P1, P0}:
  - P3 = V^H; P2 = F^H; P1 = F^V; P0 = F^V^H.
  - Bit 9 must be 1.
- Good XY: update H/V/F, pulse `trs_valid`.
- Bad XY: pulse `xy_error`; H/V/F hold; no `trs_valid`.
- `sample_count`:
  - Increments each cycle; wraps LINE_WORDS-1 → 0.
  - On a valid EAV (H=1) it is forced to 3, which resyncs it.
  - SAV does not touch it.
- `line_count`:
  - Increments on each valid EAV; wraps LINE_COUNT-1 → 0.
  - A valid EAV whose F is 0 while the previous F was 1 clears it to 0 and pulses `frame_start`. Clear takes priority over increment.
- An EAV is on-time when the free-running `sample_count` would have been 3 in that cycle anyway.
- Lock FSM:
  - UNLOCKED: valid EAV → ACQUIRE, good=1.
  - ACQUIRE:
    - On-time EAV → good+1; good reaching LOCK_LINES → LOCKED.
    - Off-time EAV → good=1, stay in ACQUIRE.
    - `xy_error` → UNLOCKED.
  - LOCKED: `locked`=1. Off-time EAV, `xy_error`, or `sample_count` reaching 3 with no valid EAV → UNLOCKED.
- Simultaneous events: a bad XY on an expected EAV slot counts as both error and missed EAV, giving a single transition to UNLOCKED.

## Timing
- Latency in → out: 1 cycle. `trs_valid`/`xy_error`/H/V/F/counters update on the same edge that presents the XY word on `bt656_stream_out`.
- Reset values:
  - `bt656_stream_out` = 0.
  - `trs_valid`, `xy_error`, `frame_start`, H, V, F, `locked` = 0.
  - `sample_count` = 0, `line_count` = 0.
  - History = 0, so no false TRS can form across reset. FSM = UNLOCKED.
- Reset mid-line: all state is dropped immediately. A TRS whose preamble straddles the reset deassertion is not detected.
- Back-to-back TRS (e.g. 3FF 000 000 XY 3FF 000 000 XY) are both detected; there is no detection dead time.
- 3FF/000 words inside active video never match, since 3FF and 000 are reserved values in the stream.

## Structure
- Shared package/include `bt656_pkg`:
  - TRS constants: 3FF and 000 preamble words.
  - XY bit positions (F=8, V=7, H=6).
  - Lock FSM state encodings.
  - NTSC defaults (1716, 525).
- Sub-module `bt656_xy_check`: combinational; XY word → {F, V, H, ok}. Reused by the downstream descrambler's regenerator.
- Top: history registers, counters, and lock FSM.

## Test plan
- Clean NTSC: 10 frames of valid 1716×525 stream, EAV XY=0x9D/SAV 0x80 per field → `locked` rises on the 4th EAV (line_count 3). `sample_count` reads 3 on each EAV XY, `frame_start` once per frame, zero `xy_error`.
- Corrupted XY: flip P0 in one EAV XY in locked state → `xy_error` pulse, `trs_valid` absent, H/V/F unchanged, `locked` falls that cycle, relock after 4 good EAVs.
- Shifted line: one line shortened to 1710 words → off-time EAV; `sample_count` resyncs to 3, FSM goes UNLOCKED→ACQUIRE, relock 3 lines later.
- Missing EAV: replace one EAV preamble with blanking 0x200 → `locked` drops when `sample_count` hits 3; `line_count` does not increment that line.
- Reset mid-preamble: assert `reset_n`=0 after 3FF 000, release before 000 XY → no `trs_valid`; all outputs read 0 during reset.
- Back-to-back TRS and `COMPARE_8BIT`=1 with nonzero LSBs (3FE, 001, 002, XY|1) → both TRS detected; with `COMPARE_8BIT`=0 the LSB variant is not detected.
